// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA timing generator with pixel-rate prescaler, sync/blank decode and frame strobe
module vga_sync_gen #(
    parameter int CLK_DIV   = 4,
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clk,
    input  logic       reset,
    output logic       p_tick,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       frame_end
);
    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
    localparam logic [9:0] H_MAX    = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_MAX    = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
    localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic [DW-1:0] div_cnt;
    logic [9:0]    x_next, y_next;
    logic          h_end, v_end;

    assign p_tick = div_cnt == DIV_MAX;

    // next-state coordinates; sync/blank registers decode these so they stay aligned with pixel_x/pixel_y
    always_comb begin
        h_end  = pixel_x == H_MAX;
        v_end  = pixel_y == V_MAX;
        x_next = p_tick ? (h_end ? '0 : pixel_x + 10'd1) : pixel_x;
        y_next = (p_tick && h_end) ? (v_end ? '0 : pixel_y + 10'd1) : pixel_y;
    end

    // prescaler, coordinate counters, registered sync/blank decode and frame strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt   <= '0;
            pixel_x   <= '0;
            pixel_y   <= '0;
            hsync     <= 1'b1;
            vsync     <= 1'b1;
            video_on  <= 1'b0;
            frame_end <= 1'b0;
        end else begin
            div_cnt   <= p_tick ? '0 : div_cnt + DW'(1);
            pixel_x   <= x_next;
            pixel_y   <= y_next;
            hsync     <= !(x_next >= HS_START && x_next <= HS_END);
            vsync     <= !(y_next >= VS_START && y_next <= VS_END);
            video_on  <= x_next < H_VIS && y_next < V_VIS;
            frame_end <= p_tick && h_end && v_end;
        end
    end
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: scoreboard and vector bench for a default-size and a shrunken VGA timing generator
module tb_vga_sync_gen;
    typedef struct packed {
        logic       pt, hs, vs, von, fe;
        logic [9:0] x, y;
    } out_t;

    typedef struct {
        bit d;
        int n;
        int x, y;
        bit hs, vs, von, fe, pt;
    } spot_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       pt_d, hs_d, vs_d, von_d, fe_d;
    logic [9:0] x_d, y_d;
    logic       pt_s, hs_s, vs_s, von_s, fe_s;
    logic [9:0] x_s, y_s;

    int   total = 0, bad = 0;
    int   n = 0, seg = 0;
    out_t q_s[$], q_d[$];
    spot_t spots[$];
    int   cnt_pt_d = 0, hs_low_d = 0, von_cnt_d = 0, fall_x = -1, rise_x = -1;
    int   vs_low_s = 0, von_cnt_s = 0, fe_cnt = 0, last_fe = 0;
    logic prev_hs_d = 1'b1, prev_vs_s = 1'b1;

    always #5 clk = ~clk;

    vga_sync_gen dut_d (
        .clk(clk), .reset(reset), .p_tick(pt_d), .hsync(hs_d), .vsync(vs_d),
        .video_on(von_d), .pixel_x(x_d), .pixel_y(y_d), .frame_end(fe_d)
    );

    vga_sync_gen #(
        .CLK_DIV(3), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
    ) dut_s (
        .clk(clk), .reset(reset), .p_tick(pt_s), .hsync(hs_s), .vsync(vs_s),
        .video_on(von_s), .pixel_x(x_s), .pixel_y(y_s), .frame_end(fe_s)
    );

    // Reference: outputs as a function of clocks elapsed since reset release
    function automatic out_t model(int cyc, int div, int hd, int hf, int hw, int hb,
                                   int vd, int vf, int vw, int vb);
        out_t o;
        int ht, vt, p, f, x, y;
        ht = hd + hf + hw + hb;
        vt = vd + vf + vw + vb;
        p = cyc / div;
        f = p % (ht * vt);
        x = f % ht;
        y = f / ht;
        o.pt  = (cyc % div) == div - 1;
        o.hs  = !(x >= hd + hf && x < hd + hf + hw);
        o.vs  = !(y >= vd + vf && y < vd + vf + vw);
        o.von = cyc > 0 && x < hd && y < vd;
        o.fe  = cyc > 0 && (cyc % div) == 0 && p > 0 && f == 0;
        o.x   = 10'(x);
        o.y   = 10'(y);
        return o;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s n=%0d got=%0d want=%0d", name, n, act, exp);
        end
    endtask

    task automatic sb(string name, out_t act, out_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 20)
                $display("FAIL %s n=%0d got pt=%b hs=%b vs=%b von=%b fe=%b x=%0d y=%0d want pt=%b hs=%b vs=%b von=%b fe=%b x=%0d y=%0d",
                         name, n, act.pt, act.hs, act.vs, act.von, act.fe, act.x, act.y,
                         exp.pt, exp.hs, exp.vs, exp.von, exp.fe, exp.x, exp.y);
        end
    endtask

    task automatic tick();
        out_t es, ed, as_, ad, sp;
        @(posedge clk);
        n = reset ? 0 : n + 1;
        q_s.push_back(model(n, 3, 8, 2, 3, 2, 6, 1, 2, 1));
        q_d.push_back(model(n, 4, 640, 16, 96, 48, 480, 10, 2, 33));
        @(negedge clk);
        es = q_s.pop_front();
        ed = q_d.pop_front();
        as_ = {pt_s, hs_s, vs_s, von_s, fe_s, x_s, y_s};
        ad  = {pt_d, hs_d, vs_d, von_d, fe_d, x_d, y_d};
        sb("sb_small", as_, es);
        sb("sb_default", ad, ed);
        foreach (spots[i]) begin
            if (seg == 0 && spots[i].n == n) begin
                sp = {spots[i].pt, spots[i].hs, spots[i].vs, spots[i].von, spots[i].fe,
                      10'(spots[i].x), 10'(spots[i].y)};
                sb(spots[i].d ? "spot_default" : "spot_small", spots[i].d ? ad : as_, sp);
            end
        end
        if (seg == 0 && !reset && n >= 1) begin
            if (n <= 40 && pt_d) cnt_pt_d++;
            if (n <= 3200) begin
                if (pt_d && !hs_d) hs_low_d++;
                if (pt_d && von_d) von_cnt_d++;
                if (hs_d != prev_hs_d) begin
                    if (!hs_d) fall_x = int'(x_d);
                    else rise_x = int'(x_d);
                end
            end
            if (n <= 450 && pt_s) begin
                if (!vs_s) vs_low_s++;
                if (von_s) von_cnt_s++;
            end
            if (n <= 1350 && fe_s) begin
                fe_cnt++;
                chk("fe_spacing", n - last_fe, 450);
                chk("fe_at_origin", {x_s, y_s}, 0);
                last_fe = n;
            end
        end
        if (vs_s != prev_vs_s) chk("vsync_at_xwrap", x_s, 0);
        prev_hs_d = hs_d;
        prev_vs_s = vs_s;
    endtask

    initial begin
        int k, fe_seen;
        //                 d   n     x    y  hs vs von fe pt
        spots.push_back('{1, 0,    0,   0, 1, 1, 0, 0, 0});
        spots.push_back('{1, 1,    0,   0, 1, 1, 1, 0, 0});
        spots.push_back('{1, 3,    0,   0, 1, 1, 1, 0, 1});
        spots.push_back('{1, 4,    1,   0, 1, 1, 1, 0, 0});
        spots.push_back('{1, 2556, 639, 0, 1, 1, 1, 0, 0});
        spots.push_back('{1, 2560, 640, 0, 1, 1, 0, 0, 0});
        spots.push_back('{1, 2624, 656, 0, 0, 1, 0, 0, 0});
        spots.push_back('{1, 3008, 752, 0, 1, 1, 0, 0, 0});
        spots.push_back('{1, 3200, 0,   1, 1, 1, 1, 0, 0});
        spots.push_back('{0, 1,    0,   0, 1, 1, 1, 0, 0});
        spots.push_back('{0, 2,    0,   0, 1, 1, 1, 0, 1});
        spots.push_back('{0, 21,   7,   0, 1, 1, 1, 0, 0});
        spots.push_back('{0, 24,   8,   0, 1, 1, 0, 0, 0});
        spots.push_back('{0, 30,   10,  0, 0, 1, 0, 0, 0});
        spots.push_back('{0, 39,   13,  0, 1, 1, 0, 0, 0});
        spots.push_back('{0, 315,  0,   7, 1, 0, 0, 0, 0});
        spots.push_back('{0, 450,  0,   0, 1, 1, 1, 1, 0});
        spots.push_back('{0, 453,  1,   0, 1, 1, 1, 0, 0});

        reset = 1'b1;
        repeat (5) tick();
        reset = 1'b0;
        repeat (3400) tick();
        chk("ptick_in_40", cnt_pt_d, 10);
        chk("hsync_low_ticks", hs_low_d, 96);
        chk("hsync_fall_x", fall_x, 656);
        chk("hsync_rise_x", rise_x, 752);
        chk("video_on_line_ticks", von_cnt_d, 640);
        chk("vsync_low_ticks_small", vs_low_s, 30);
        chk("video_on_frame_ticks_small", von_cnt_s, 48);
        chk("frame_end_count", fe_cnt, 3);

        reset = 1'b1;
        repeat (5) begin
            tick();
            chk("rst_state", {pt_d, hs_d, vs_d, von_d, fe_d, x_d, y_d}, {5'b01100, 20'd0});
        end
        seg = 1;
        reset = 1'b0;
        tick();
        chk("video_on_after_release", von_d, 1);

        k = 0;
        while (!(x_s == 10'd11 && y_s == 10'd7) && k < 2000) begin
            tick();
            k++;
        end
        chk("reach_sync_region", k < 2000, 1);
        chk("pre_rst_syncs_low", {hs_s, vs_s}, 2'b00);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midsync_rst", {hs_s, vs_s, fe_s, x_s, y_s}, {3'b110, 20'd0});
        fe_seen = 0;
        repeat (20) begin
            tick();
            fe_seen += int'(fe_s);
        end
        chk("no_fe_after_rst", fe_seen, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
